// File: rtl/udp_pkg.sv
// Shared UDP framing types, widths and the header byte generator.
// Latency: n/a (package, combinational helper only).
// Backpressure: n/a.
package udp_pkg;

    localparam int UDP_HDR_LEN = 8;
    localparam int PORT_W      = 16;
    localparam int LEN_W       = 11;
    localparam int UDP_LEN_W   = 16;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        HDR,
        PAY,
        GAP
    } state_e;

    // Per-frame context captured at arbitration and frozen for the whole frame.
    typedef struct packed {
        logic [PORT_W-1:0] dst_port;
        logic [LEN_W-1:0]  len;
    } frame_t;

    // Header byte idx of a UDP header; checksum bytes (6,7) are zero (disabled).
    function automatic logic [7:0] udp_hdr_byte(
        input logic [2:0]        idx,
        input logic [PORT_W-1:0] src_port,
        input logic [PORT_W-1:0] dst_port,
        input logic [LEN_W-1:0]  len
    );
        logic [UDP_LEN_W-1:0] ulen;
        ulen = UDP_LEN_W'(len) + UDP_LEN_W'(UDP_HDR_LEN);
        case (idx)
            3'd0:    udp_hdr_byte = src_port[15:8];
            3'd1:    udp_hdr_byte = src_port[7:0];
            3'd2:    udp_hdr_byte = dst_port[15:8];
            3'd3:    udp_hdr_byte = dst_port[7:0];
            3'd4:    udp_hdr_byte = ulen[15:8];
            3'd5:    udp_hdr_byte = ulen[7:0];
            default: udp_hdr_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, wrapping; one-hot grant plus index.
// Latency: purely combinational.
// Backpressure: none; caller decides when to consume the grant and advance ptr.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan from ptr upward modulo N; the first hit wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[(int'(ptr) + i) % N]) begin
                any                       = 1'b1;
                gnt[(int'(ptr) + i) % N]  = 1'b1;
                idx                       = IW'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Round-robin shares one UDP byte stream among NUM_REQ sources: 8-byte header, payload, gap.
// Latency: first header byte valid 3 cycles after req seen in IDLE; payload bytes pass in 1 cycle.
// Backpressure: one-byte output register holds on udp_ready=0; pl_ready only while udp_ready=1.
module udp_tx_scheduler #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned SRC_PORT    = 5000,
    parameter int unsigned MAX_PAYLOAD = 1472,
    parameter int unsigned GAP_CYCLES  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [16*NUM_REQ-1:0] req_dst_port,
    input  logic [11*NUM_REQ-1:0] req_len,
    input  logic [8*NUM_REQ-1:0]  pl_data,
    input  logic [NUM_REQ-1:0]    pl_valid,
    output logic [NUM_REQ-1:0]    pl_ready,
    output logic [NUM_REQ-1:0]    grant,
    output logic [7:0]            udp_data,
    output logic                  udp_valid,
    output logic                  udp_last,
    input  logic                  udp_ready,
    output logic                  busy
);
    import udp_pkg::*;

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [PORT_W-1:0] SRC     = PORT_W'(SRC_PORT);
    localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(MAX_PAYLOAD);

    state_e              state_q, state_d;
    logic [IW-1:0]       ptr_q, g_q;
    logic [NUM_REQ-1:0]  grant_q;
    frame_t              ctx_q;
    logic [LEN_W-1:0]    cnt_q;
    logic [GW-1:0]       gap_q;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IW-1:0]       arb_idx;
    logic                arb_any;
    logic [PORT_W-1:0]   arb_dst;
    logic [LEN_W-1:0]    arb_len_raw, arb_len;

    logic                xfer, out_free, hdr_ld, hdr_end, pay_rdy, take, last_done, gap_end;
    logic [7:0]          pay_byte;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign arb_dst     = req_dst_port[PORT_W*int'(arb_idx) +: PORT_W];
    assign arb_len_raw = req_len[LEN_W*int'(arb_idx) +: LEN_W];
    assign arb_len     = (arb_len_raw > MAX_LEN) ? MAX_LEN : arb_len_raw;

    assign xfer      = udp_valid & udp_ready;
    assign out_free  = ~udp_valid | udp_ready;
    // Header bytes load whenever the output register has room, so they never bubble.
    assign hdr_ld    = (state_q == HDR) && out_free && (cnt_q < LEN_W'(UDP_HDR_LEN));
    assign hdr_end   = hdr_ld && (cnt_q == LEN_W'(UDP_HDR_LEN - 1));
    assign pay_rdy   = (state_q == PAY) && udp_ready && (cnt_q < ctx_q.len);
    assign take      = pay_rdy & pl_valid[g_q];
    assign pay_byte  = pl_data[8*int'(g_q) +: 8];
    assign last_done = xfer & udp_last;
    assign gap_end   = (gap_q == GW'(GAP_CYCLES - 1));

    assign grant = grant_q;
    assign busy  = (state_q != IDLE);

    // Only the granted source sees ready.
    always_comb begin
        pl_ready       = '0;
        pl_ready[g_q]  = pay_rdy;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: frame ends only once its last byte has left the output register.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (|req) state_d = ARB;
            ARB:  state_d = arb_any ? HDR : IDLE;
            HDR: begin
                if (hdr_end && (ctx_q.len != '0)) state_d = PAY;
                else if (last_done)               state_d = GAP;
            end
            PAY:  if (last_done) state_d = GAP;
            GAP:  if (gap_end)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Arbitration capture, byte and gap counters; grant drops with the last byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            g_q     <= '0;
            grant_q <= '0;
            ctx_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
        end else begin
            case (state_q)
                ARB: begin
                    if (arb_any) begin
                        grant_q        <= arb_gnt;
                        g_q            <= arb_idx;
                        ctx_q.dst_port <= arb_dst;
                        ctx_q.len      <= arb_len;
                        ptr_q          <= (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                        cnt_q          <= '0;
                    end
                end
                HDR: begin
                    if (hdr_ld) cnt_q <= (hdr_end && (ctx_q.len != '0)) ? '0 : cnt_q + 1'b1;
                end
                PAY: begin
                    if (take) cnt_q <= cnt_q + 1'b1;
                end
                GAP: gap_q <= gap_q + 1'b1;
                default: ;
            endcase
            if (last_done) begin
                grant_q <= '0;
                gap_q   <= '0;
            end
        end
    end

    // One-byte output register: holds while stalled, empties when nothing new is loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            udp_data  <= '0;
            udp_valid <= 1'b0;
            udp_last  <= 1'b0;
        end else if (last_done) begin
            udp_valid <= 1'b0;
            udp_last  <= 1'b0;
        end else if (hdr_ld) begin
            udp_data  <= udp_hdr_byte(cnt_q[2:0], SRC, ctx_q.dst_port, ctx_q.len);
            udp_valid <= 1'b1;
            udp_last  <= hdr_end && (ctx_q.len == '0);
        end else if (take) begin
            udp_data  <= pay_byte;
            udp_valid <= 1'b1;
            udp_last  <= (cnt_q == ctx_q.len - LEN_W'(1));
        end else if (xfer) begin
            udp_valid <= 1'b0;
            udp_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Self-checking bench: scoreboard of expected bytes, checked by a monitor on each transfer.
// Latency: n/a.
// Backpressure: udp_ready driven always-high or toggling per scenario.
module tb_udp_tx_scheduler;

    localparam int GAP = 12;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [1:0] grant;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [31:0] req_dst_port;
    logic [21:0] req_len;
    logic [15:0] pl_data;
    logic [1:0]  pl_valid;
    logic [1:0]  pl_ready;
    logic [1:0]  grant;
    logic [7:0]  udp_data;
    logic        udp_valid;
    logic        udp_last;
    logic        udp_ready;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    exp_t sb[$];

    logic [7:0] sbytes [2][16];
    int  slen[2];
    int  sidx[2];
    int  hold[2];
    bit  gap_mode     = 1'b0;
    bit  ready_toggle = 1'b0;
    bit  gap_chk      = 1'b0;

    int  bytes_seen   = 0;
    int  frames_done  = 0;
    int  bubble_cnt   = 0;
    int  idle_cnt     = 0;
    bit  in_frame     = 1'b0;
    bit  pl_ready_seen = 1'b0;
    bit  hold_v       = 1'b0;
    logic [7:0] hold_d;
    logic       hold_l;

    always #5 clk = ~clk;

    udp_tx_scheduler #(
        .NUM_REQ     (2),
        .SRC_PORT    (5000),
        .MAX_PAYLOAD (1472),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_dst_port (req_dst_port),
        .req_len      (req_len),
        .pl_data      (pl_data),
        .pl_valid     (pl_valid),
        .pl_ready     (pl_ready),
        .grant        (grant),
        .udp_data     (udp_data),
        .udp_valid    (udp_valid),
        .udp_last     (udp_last),
        .udp_ready    (udp_ready),
        .busy         (busy)
    );

    // Source models and downstream ready: handshake captured at negedge, state advanced after posedge.
    initial begin
        logic [1:0] fire;
        pl_valid  = '0;
        pl_data   = '0;
        udp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            slen[i] = 0; sidx[i] = 0; hold[i] = 0;
        end
        forever begin
            @(negedge clk);
            fire = pl_valid & pl_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (hold[i] > 0) hold[i]--;
                else if (fire[i]) begin
                    sidx[i]++;
                    if (gap_mode && sidx[i] == 4) hold[i] = 3;
                end
                pl_valid[i]        = (sidx[i] < slen[i]) && (hold[i] == 0);
                pl_data[8*i +: 8]  = (sidx[i] < 16) ? sbytes[i][sidx[i]] : 8'h00;
            end
            udp_ready = ready_toggle ? ~udp_ready : 1'b1;
        end
    end

    // Monitor: scoreboard compare per transfer, stall stability, inter-frame gap, payload bubbles.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_v   = 1'b0;
                in_frame = 1'b0;
                idle_cnt = 0;
            end else begin
                if (pl_ready != 2'b00) pl_ready_seen = 1'b1;
                if (hold_v) begin
                    checks++;
                    if (!udp_valid || udp_data !== hold_d || udp_last !== hold_l) begin
                        failures++;
                        $display("FAIL stall_hold got valid=%0b data=%02h last=%0b expected valid=1 data=%02h last=%0b",
                                 udp_valid, udp_data, udp_last, hold_d, hold_l);
                    end
                end
                hold_v = udp_valid && !udp_ready;
                hold_d = udp_data;
                hold_l = udp_last;
                if (udp_valid && udp_ready) begin
                    if (gap_chk && !in_frame && frames_done > 0) begin
                        checks++;
                        if (idle_cnt < GAP + 2) begin
                            failures++;
                            $display("FAIL frame_gap got %0d idle cycles expected >= %0d", idle_cnt, GAP + 2);
                        end
                    end
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_byte got data=%02h last=%0b expected no transfer", udp_data, udp_last);
                    end else begin
                        e = sb.pop_front();
                        if (udp_data !== e.data || udp_last !== e.last || grant !== e.grant) begin
                            failures++;
                            $display("FAIL byte_%0d got data=%02h last=%0b grant=%b expected data=%02h last=%0b grant=%b",
                                     bytes_seen, udp_data, udp_last, grant, e.data, e.last, e.grant);
                        end
                    end
                    bytes_seen++;
                    in_frame = 1'b1;
                    if (udp_last) begin
                        frames_done++;
                        in_frame = 1'b0;
                        idle_cnt = 0;
                    end
                end else if (!udp_valid) begin
                    idle_cnt++;
                    if (in_frame) bubble_cnt++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic push_frame(input int s, input logic [15:0] dst, input int len, input int off);
        logic [7:0]  h[8];
        logic [15:0] ul;
        exp_t        e;
        ul   = 16'(len + 8);
        h[0] = 8'h13; h[1] = 8'h88;
        h[2] = dst[15:8]; h[3] = dst[7:0];
        h[4] = ul[15:8];  h[5] = ul[7:0];
        h[6] = 8'h00;     h[7] = 8'h00;
        e.grant = 2'(1 << s);
        for (int k = 0; k < 8; k++) begin
            e.data = h[k];
            e.last = (len == 0) && (k == 7);
            sb.push_back(e);
        end
        for (int k = 0; k < len; k++) begin
            e.data = sbytes[s][off + k];
            e.last = (k == len - 1);
            sb.push_back(e);
        end
    endtask

    task automatic set_src(input int s, input int n, input logic [7:0] base);
        for (int k = 0; k < 16; k++) sbytes[s][k] = base + 8'(k);
        slen[s] = n; sidx[s] = 0; hold[s] = 0;
    endtask

    task automatic set_fields(input int s, input logic [15:0] dst, input logic [10:0] len);
        req_dst_port[16*s +: 16] = dst;
        req_len[11*s +: 11]      = len;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        req = 2'b00;
        gap_mode = 1'b0; ready_toggle = 1'b0; gap_chk = 1'b0;
        sb.delete();
        bytes_seen = 0; frames_done = 0; bubble_cnt = 0; pl_ready_seen = 1'b0;
        for (int i = 0; i < 2; i++) begin slen[i] = 0; sidx[i] = 0; hold[i] = 0; end
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(posedge clk); #2;
            if (grant != 2'b00) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(posedge clk); #2;
            if (sb.size() == 0 && !busy) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        #4;
        checks++;
        if ({udp_valid, udp_last, udp_data} !== 10'b0) begin
            failures++;
            $display("FAIL reset_out got valid=%0b last=%0b data=%02h expected 0 0 00", udp_valid, udp_last, udp_data);
        end
        checks++;
        if ({grant, pl_ready, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctl got grant=%b pl_ready=%b busy=%0b expected 00 00 0", grant, pl_ready, busy);
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b0 || udp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got busy=%0b valid=%0b expected 0 0", busy, udp_valid);
        end
    endtask

    task automatic test_single();
        bit    ok;
        string hw = "Hello World";
        do_reset();
        for (int k = 0; k < 11; k++) sbytes[0][k] = hw[k];
        slen[0] = 11; sidx[0] = 0;
        set_fields(0, 16'd5001, 11'd11);
        push_frame(0, 16'd5001, 11, 0);
        req = 2'b01;
        wait_grant(ok);
        checks++;
        if (!ok || grant !== 2'b01) begin
            failures++;
            $display("FAIL single_grant got %b expected 01", grant);
        end
        req = 2'b00;
        wait_idle(500, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL single_done got pending=%0d expected 0", sb.size()); end
        checks++;
        if (bytes_seen !== 19 || frames_done !== 1) begin
            failures++;
            $display("FAIL single_count got bytes=%0d frames=%0d expected 19 1", bytes_seen, frames_done);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        set_src(0, 8, 8'hA0);
        set_src(1, 8, 8'hB0);
        set_fields(0, 16'h1111, 11'd4);
        set_fields(1, 16'h2222, 11'd4);
        push_frame(0, 16'h1111, 4, 0);
        push_frame(1, 16'h2222, 4, 0);
        push_frame(0, 16'h1111, 4, 4);
        push_frame(1, 16'h2222, 4, 4);
        gap_chk = 1'b1;
        req = 2'b11;
        ok = 1'b0;
        for (int c = 0; c < 600 && !ok; c++) begin
            @(posedge clk); #2;
            if (frames_done >= 4) ok = 1'b1;
        end
        req = 2'b00;
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_frames got %0d expected 4", frames_done); end
        wait_idle(100, ok);
        checks++;
        if (!ok || frames_done !== 4 || bytes_seen !== 48) begin
            failures++;
            $display("FAIL b2b_count got frames=%0d bytes=%0d expected 4 48", frames_done, bytes_seen);
        end
        gap_chk = 1'b0;
    endtask

    task automatic test_len0();
        bit ok;
        do_reset();
        set_src(0, 4, 8'hC0);
        set_fields(0, 16'h1234, 11'd0);
        push_frame(0, 16'h1234, 0, 0);
        req = 2'b01;
        wait_grant(ok);
        checks++;
        if (!ok || grant !== 2'b01) begin failures++; $display("FAIL len0_grant got %b expected 01", grant); end
        req = 2'b00;
        wait_idle(200, ok);
        checks++;
        if (!ok || bytes_seen !== 8) begin
            failures++;
            $display("FAIL len0_bytes got %0d expected 8", bytes_seen);
        end
        checks++;
        if (pl_ready_seen !== 1'b0 || sidx[0] !== 0) begin
            failures++;
            $display("FAIL len0_plready got seen=%0b consumed=%0d expected 0 0", pl_ready_seen, sidx[0]);
        end
    endtask

    task automatic test_stall();
        bit ok;
        do_reset();
        ready_toggle = 1'b1;
        set_src(1, 6, 8'h30);
        set_fields(1, 16'h0050, 11'd6);
        push_frame(1, 16'h0050, 6, 0);
        req = 2'b10;
        wait_grant(ok);
        checks++;
        if (!ok || grant !== 2'b10) begin failures++; $display("FAIL stall_grant got %b expected 10", grant); end
        req = 2'b00;
        wait_idle(300, ok);
        checks++;
        if (!ok || bytes_seen !== 14) begin
            failures++;
            $display("FAIL stall_bytes got %0d expected 14", bytes_seen);
        end
        ready_toggle = 1'b0;
    endtask

    task automatic test_pl_gap();
        bit ok;
        do_reset();
        gap_mode = 1'b1;
        set_src(0, 10, 8'h50);
        set_fields(0, 16'h0777, 11'd10);
        push_frame(0, 16'h0777, 10, 0);
        req = 2'b01;
        wait_grant(ok);
        req = 2'b00;
        wait_idle(300, ok);
        checks++;
        if (!ok || bytes_seen !== 18) begin
            failures++;
            $display("FAIL plgap_bytes got %0d expected 18", bytes_seen);
        end
        checks++;
        if (bubble_cnt !== 3) begin
            failures++;
            $display("FAIL plgap_bubbles got %0d expected 3", bubble_cnt);
        end
        gap_mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        set_src(0, 10, 8'h60);
        set_fields(0, 16'd7000, 11'd10);
        push_frame(0, 16'd7000, 10, 0);
        req = 2'b01;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(posedge clk); #2;
            if (bytes_seen >= 13) ok = 1'b1;
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL rstmid_reach got %0d bytes expected 13", bytes_seen); end
        rst = 1'b1;
        #1;
        checks++;
        if ({udp_valid, udp_last, udp_data} !== 10'b0) begin
            failures++;
            $display("FAIL rstmid_out got valid=%0b last=%0b data=%02h expected 0 0 00", udp_valid, udp_last, udp_data);
        end
        checks++;
        if ({grant, pl_ready, busy} !== 5'b0) begin
            failures++;
            $display("FAIL rstmid_ctl got grant=%b pl_ready=%b busy=%0b expected 00 00 0", grant, pl_ready, busy);
        end
        sb.delete();
        req = 2'b00;
        bytes_seen = 0;
        frames_done = 0;
        @(posedge clk); #2;
        rst = 1'b0;
        set_src(1, 3, 8'h70);
        set_fields(1, 16'd6000, 11'd3);
        push_frame(1, 16'd6000, 3, 0);
        req = 2'b10;
        wait_grant(ok);
        checks++;
        if (!ok || grant !== 2'b10) begin failures++; $display("FAIL rstmid_grant got %b expected 10", grant); end
        req = 2'b00;
        wait_idle(200, ok);
        checks++;
        if (!ok || bytes_seen !== 11) begin
            failures++;
            $display("FAIL rstmid_bytes got %0d expected 11", bytes_seen);
        end
    endtask

    initial begin
        rst          = 1'b0;
        req          = 2'b00;
        req_dst_port = '0;
        req_len      = '0;
        #1 rst = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_len0();
        test_stall();
        test_pl_gap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
